// File: rtl/float_unit_sequencer.sv
// Drives a fixed-latency float unit over a run of LEN operands and buffers its
// results in a small FIFO. Issue is credit-limited so a result always has a slot.
module float_unit_sequencer #(
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [LEN_W-1:0]  len,
  output logic              running,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] fu_in,
  input  logic [DATA_W-1:0] fu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [LEN_W-1:0]   len_q, issued, popped;
  logic [LATENCY-1:0] vpipe, vpipe_next;
  logic [INF_W-1:0]   inflight;
  logic [31:0]        occupancy;
  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               run_accept, issue, push, pop, credit_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign run_accept = (state == IDLE) && run;
  assign push       = vpipe[LATENCY-1];
  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = mem[rd_ptr];
  assign running    = (state != IDLE);
  assign done       = (state == DONE);
  assign in_ready   = (state == BUSY) && (issued < len_q) && credit_ok;
  assign issue      = in_valid && in_ready;

  // Credit uses registered counts only; a same-cycle pop is deliberately not
  // credited so in_ready never depends on out_ready.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch can be inferred on any path.
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + INF_W'(vpipe[i]);
    occupancy = 32'(fifo_count) + 32'(inflight);
    credit_ok = (occupancy < 32'(FIFO_DEPTH));
  end

  always_comb begin
    vpipe_next    = vpipe << 1;
    vpipe_next[0] = issue;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = (len == '0) ? DONE : BUSY;
      BUSY:    if (issued == len_q) state_next = DRAIN;
      DRAIN:   if (popped == len_q) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      issued     <= '0;
      popped     <= '0;
      vpipe      <= '0;
      fu_in      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state <= state_next;
      vpipe <= vpipe_next;
      if (run_accept) begin
        len_q  <= len;
        issued <= '0;
        popped <= '0;
      end else begin
        if (issue) issued <= issued + 1'b1;
        if (pop)   popped <= popped + 1'b1;
      end
      if (issue) fu_in  <= in_data;
      if (push)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop)   rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  // NOTE: the storage array is not reset; the cleared count and pointers make
  // stale contents unreachable, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fu_out;
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_float_unit_sequencer.sv
// Directed bench: two sequencer instances (latency 1 and 3) each driving a
// sign-flip unit model; scenario table plus hand-written reset sequences.
module tb_float_unit_sequencer;

  localparam logic [31:0] SIGN   = 32'h8000_0000;
  localparam int          BUDGET = 300;

  logic        clk = 1'b0;
  logic        rst_n, run, in_valid, out_ready, sel;
  logic [15:0] len;
  logic [31:0] in_data;

  logic        a_running, a_done, a_in_ready, a_out_valid;
  logic [31:0] a_fu_in, a_fu_out, a_out_data;
  logic        b_running, b_done, b_in_ready, b_out_valid;
  logic [31:0] b_fu_in, b_fu_out, b_out_data, b_d1, b_d2;

  logic        m_running, m_done, m_in_ready, m_out_valid;
  logic [31:0] m_out_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  float_unit_sequencer #(.DATA_W(32), .LATENCY(1), .FIFO_DEPTH(4), .LEN_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .len(len),
    .running(a_running), .done(a_done),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .fu_in(a_fu_in), .fu_out(a_fu_out),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data)
  );

  float_unit_sequencer #(.DATA_W(32), .LATENCY(3), .FIFO_DEPTH(4), .LEN_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .len(len),
    .running(b_running), .done(b_done),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .fu_in(b_fu_in), .fu_out(b_fu_out),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data)
  );

  // FloatNot units: result is due LATENCY cycles after the operand is accepted.
  assign a_fu_out = a_fu_in ^ SIGN;
  always_ff @(posedge clk) begin
    b_d1 <= b_fu_in;
    b_d2 <= b_d1;
  end
  assign b_fu_out = b_d2 ^ SIGN;

  assign m_running   = sel ? b_running   : a_running;
  assign m_done      = sel ? b_done      : a_done;
  assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
  assign m_out_valid = sel ? b_out_valid : a_out_valid;
  assign m_out_data  = sel ? b_out_data  : a_out_data;

  typedef struct {
    bit          sel;          // 0: latency 1, 1: latency 3
    logic [15:0] len;
    logic [31:0] base;
    int          stall;        // cycles out_ready held low after run
    int          exp_stall_acc;
    bit          consec;       // operands must be accepted back to back
    int          done_off;     // expected done cycle after run edge, -1 = any
    int          rerun;        // cycle to pulse run(len=5) mid-run, 0 = none
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] op(input logic [31:0] base, input int i);
    return base + (32'(i) * 32'h0001_0203);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_scenario(input vec_t v);
    int  idx, pops, dones, done_cyc, run_cycles, first, last;
    bit  acc, finished;
    idx = 0; pops = 0; dones = 0; done_cyc = -1; run_cycles = 0;
    first = -1; last = -1; finished = 1'b0;
    sel       = v.sel;
    in_valid  = 1'b1;
    out_ready = (v.stall == 0);
    in_data   = op(v.base, 0);
    run       = 1'b1;
    len       = v.len;
    @(posedge clk);
    #1 run = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !finished; cyc++) begin
      run = (cyc == v.rerun);
      if (cyc == v.rerun) len = 16'd5;
      out_ready = (cyc > v.stall);
      @(negedge clk);
      if (m_running) run_cycles++;
      acc = in_valid && m_in_ready;
      if (acc) begin
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (m_out_valid && out_ready) begin
        check("out_data", m_out_data, op(v.base, pops) ^ SIGN);
        pops++;
      end
      if (m_done) begin
        dones++;
        done_cyc = cyc;
        finished = 1'b1;
      end
      if (v.stall > 0 && cyc == v.stall) check("stall_accepts", idx + int'(acc), v.exp_stall_acc);
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        in_data = op(v.base, idx);
      end
    end
    run = 1'b0;
    check("done_seen", finished, 1);
    check("accepted", idx, v.len);
    check("popped", pops, v.len);
    check("running_span", run_cycles, done_cyc);
    if (v.done_off >= 0) check("done_cycle", done_cyc, v.done_off);
    if (v.consec) check("consecutive", last - first, int'(v.len) - 1);
    @(negedge clk);
    check("idle_after", {m_running, m_done, m_out_valid, m_in_ready}, 4'b0000);
    repeat (2) begin
      @(negedge clk);
      if (m_done) dones++;
    end
    check("done_once", dones, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 16'd8,  32'h3f80_0000, 0,  0, 1'b1, -1, 0};
    vecs[1] = '{1'b0, 16'd0,  32'h0000_0000, 0,  0, 1'b0,  1, 0};
    vecs[2] = '{1'b1, 16'd10, 32'hc000_0000, 20, 4, 1'b0, -1, 0};
    vecs[3] = '{1'b0, 16'd8,  32'h4120_0000, 0,  0, 1'b0, -1, 3};
    vecs[4] = '{1'b1, 16'd1,  32'h7f00_0001, 0,  0, 1'b0, -1, 0};
    vecs[5] = '{1'b0, 16'd3,  32'h8123_4567, 10, 3, 1'b0, -1, 0};
    vecs[6] = '{1'b1, 16'd6,  32'h0bad_f00d, 0,  0, 1'b0, -1, 0};

    rst_n = 1'b0; run = 1'b1; len = 16'd5; sel = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h1234_5678;

    // Reset held with run asserted: everything stays quiet.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_a", {a_running, a_done, a_in_ready, a_out_valid}, 4'b0000);
      check("reset_b", {b_running, b_done, b_in_ready, b_out_valid}, 4'b0000);
    end
    check("reset_fu_in", a_fu_in, 32'h0);
    run = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      run_scenario(vecs[i]);
    end

    // Reset in DRAIN with three results buffered, then a fresh short run.
    do_reset();
    sel = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0aaa;
    run = 1'b1; len = 16'd3;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("drain_buffered", {a_running, a_out_valid, a_in_ready}, 3'b110);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_reset", {a_running, a_done, a_in_ready, a_out_valid}, 4'b0000);
    run_scenario('{1'b0, 16'd2, 32'h5555_0000, 0, 0, 1'b0, -1, 0});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
